// File: rtl/sha_pkg.sv
// sha_pkg
// Shared definitions for the SHA-2 message scheduler family:
//   - sched_state_e : LOAD (taking M0..M15) / GEN (expanding W16..)
//   - SHA256_ROUNDS / SHA512_ROUNDS : schedule lengths
//   - small_sigma0 / small_sigma1 : SHA-2 message sigmas for 32- or 64-bit words.
//     Both take a 64-bit argument plus the word width. A 32-bit word lives in
//     the low half, and its result is returned zero-extended.
package sha_pkg;

  typedef enum logic {
    LOAD = 1'b0,
    GEN  = 1'b1
  } sched_state_e;

  localparam int SHA256_ROUNDS = 64;
  localparam int SHA512_ROUNDS = 80;

  function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [63:0] rotr64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [63:0] small_sigma0(input logic [63:0] x, input int w);
    logic [31:0] x32;
    x32 = x[31:0];
    if (w == 64) begin
      return rotr64(x, 1) ^ rotr64(x, 8) ^ (x >> 7);
    end
    return {32'h0, rotr32(x32, 7) ^ rotr32(x32, 18) ^ (x32 >> 3)};
  endfunction

  function automatic logic [63:0] small_sigma1(input logic [63:0] x, input int w);
    logic [31:0] x32;
    x32 = x[31:0];
    if (w == 64) begin
      return rotr64(x, 19) ^ rotr64(x, 61) ^ (x >> 6);
    end
    return {32'h0, rotr32(x32, 17) ^ rotr32(x32, 19) ^ (x32 >> 10)};
  endfunction

endpackage

// File: rtl/sha_small_sigma.sv
// sha_small_sigma
// Combinational SHA-2 message sigmas for one word width.
// Ports:
//   sig0_in -> sigma0 : sigma0 of sig0_in
//   sig1_in -> sigma1 : sigma1 of sig1_in
// WORD_W = 32 selects the SHA-256 rotations. WORD_W = 64 selects the SHA-512 rotations.
module sha_small_sigma
  import sha_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic [WORD_W-1:0] sig0_in,
  input  logic [WORD_W-1:0] sig1_in,
  output logic [WORD_W-1:0] sigma0,
  output logic [WORD_W-1:0] sigma1
);

  assign sigma0 = WORD_W'(small_sigma0(64'(sig0_in), WORD_W));
  assign sigma1 = WORD_W'(small_sigma1(64'(sig1_in), WORD_W));

endmodule

// File: rtl/sha_msg_sched.sv
// sha_msg_sched
// SHA-2 message scheduler. It takes the 16 message words of a block on the
// m stream and emits W0..W(ROUNDS-1), one word per cycle, on the w stream.
// Ports:
//   clk, rst      : clock; asynchronous active-low reset
//   abort         : synchronous flush of the block in flight
//   m_valid/m_ready/m_data : message word input stream (M0 first)
//   w_valid/w_ready/w_data : schedule word output stream
//   w_idx         : round index of w_data
//   w_last        : marks W(ROUNDS-1)
//   busy          : a block is in progress or a word is still presented
module sha_msg_sched
  import sha_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int ROUNDS = SHA256_ROUNDS,
  localparam int IDX_W = $clog2(ROUNDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              abort,
  input  logic              m_valid,
  output logic              m_ready,
  input  logic [WORD_W-1:0] m_data,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [WORD_W-1:0] w_data,
  output logic [IDX_W-1:0]  w_idx,
  output logic              w_last,
  output logic              busy
);

  if (!((WORD_W == 32 && ROUNDS == SHA256_ROUNDS) ||
        (WORD_W == 64 && ROUNDS == SHA512_ROUNDS))) begin : g_bad_cfg
    $error("sha_msg_sched: unsupported WORD_W=%0d / ROUNDS=%0d combination", WORD_W, ROUNDS);
  end

  sched_state_e      state_q, state_d;
  logic [IDX_W-1:0]  t_q, t_d;
  logic [WORD_W-1:0] win_q [16];
  logic [WORD_W-1:0] win_d [16];
  logic              w_valid_q, w_valid_d;
  logic [WORD_W-1:0] w_data_q, w_data_d;
  logic [IDX_W-1:0]  w_idx_q, w_idx_d;
  logic              w_last_q, w_last_d;

  logic [WORD_W-1:0] sigma0, sigma1;
  logic [WORD_W-1:0] gen_word;
  logic [WORD_W-1:0] load_word;
  logic              slot_free;
  logic              m_fire;
  logic              gen_fire;
  logic              w_fire;
  logic              t_is_15;
  logic              t_is_last;

  sha_small_sigma #(
    .WORD_W (WORD_W)
  ) u_sigma (
    .sig0_in (win_q[1]),
    .sig1_in (win_q[14]),
    .sigma0  (sigma0),
    .sigma1  (sigma1)
  );

  // The window holds W(t-16)..W(t-1), so the taps are fixed offsets into it.
  // The sum wraps at WORD_W bits.
  assign gen_word = sigma1 + win_q[9] + sigma0 + win_q[0];

  assign slot_free = !w_valid_q || w_ready;
  // rst is in the m_ready term so that m_ready reads 0 for the whole time reset is held.
  assign m_ready   = rst && (state_q == LOAD) && slot_free;
  assign m_fire    = m_valid && m_ready;
  assign gen_fire  = (state_q == GEN) && slot_free;
  assign w_fire    = w_valid_q && w_ready;
  assign load_word = (state_q == LOAD) ? m_data : gen_word;
  assign t_is_15   = (t_q == IDX_W'(15));
  assign t_is_last = (t_q == IDX_W'(ROUNDS - 1));

  // abort takes priority over any handshake. A new load takes priority over
  // clearing w_valid, so back-to-back words never create a bubble.
  always_comb begin
    state_d   = state_q;
    t_d       = t_q;
    win_d     = win_q;
    w_valid_d = w_valid_q;
    w_data_d  = w_data_q;
    w_idx_d   = w_idx_q;
    w_last_d  = w_last_q;

    if (abort) begin
      state_d   = LOAD;
      t_d       = '0;
      w_valid_d = 1'b0;
      w_last_d  = 1'b0;
    end else if (m_fire || gen_fire) begin
      for (int i = 0; i < 15; i++) begin
        win_d[i] = win_q[i + 1];
      end
      win_d[15] = load_word;
      w_valid_d = 1'b1;
      w_data_d  = load_word;
      w_idx_d   = t_q;
      w_last_d  = (state_q == GEN) && t_is_last;
      t_d       = t_is_last ? '0 : t_q + IDX_W'(1);
      if (state_q == LOAD && t_is_15) begin
        state_d = GEN;
      end else if (state_q == GEN && t_is_last) begin
        state_d = LOAD;
      end
    end else if (w_fire) begin
      w_valid_d = 1'b0;
      w_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= LOAD;
      t_q       <= '0;
      w_valid_q <= 1'b0;
      w_data_q  <= '0;
      w_idx_q   <= '0;
      w_last_q  <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      w_valid_q <= w_valid_d;
      w_data_q  <= w_data_d;
      w_idx_q   <= w_idx_d;
      w_last_q  <= w_last_d;
      win_q     <= win_d;
    end
  end

  assign w_valid = w_valid_q;
  assign w_data  = w_data_q;
  assign w_idx   = w_idx_q;
  assign w_last  = w_last_q;
  assign busy    = (state_q == GEN) || (t_q != '0) || w_valid_q;

endmodule

// File: tb/tb_sha_msg_sched.sv
// tb_sha_msg_sched
// Drives a SHA-256 instance and a SHA-512 instance of the scheduler.
// The expected schedule comes from the textbook recurrence
// W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16].
module tb_sha_msg_sched;

  logic        clk;
  logic        rst;

  logic        abort32, m_valid32, m_ready32, w_valid32, w_ready32, w_last32, busy32;
  logic [31:0] m_data32, w_data32;
  logic [5:0]  w_idx32;

  logic        abort64, m_valid64, m_ready64, w_valid64, w_ready64, w_last64, busy64;
  logic [63:0] m_data64, w_data64;
  logic [6:0]  w_idx64;

  int checks;
  int errors;

  typedef struct {
    logic [63:0] data;
    int          idx;
    bit          last;
  } exp_t;

  logic [63:0] msg_q[$];
  exp_t        exp_q[$];
  logic [63:0] got [80];

  sha_msg_sched #(.WORD_W(32), .ROUNDS(64)) dut32 (
    .clk(clk), .rst(rst), .abort(abort32),
    .m_valid(m_valid32), .m_ready(m_ready32), .m_data(m_data32),
    .w_valid(w_valid32), .w_ready(w_ready32), .w_data(w_data32),
    .w_idx(w_idx32), .w_last(w_last32), .busy(busy32)
  );

  sha_msg_sched #(.WORD_W(64), .ROUNDS(80)) dut64 (
    .clk(clk), .rst(rst), .abort(abort64),
    .m_valid(m_valid64), .m_ready(m_ready64), .m_data(m_data64),
    .w_valid(w_valid64), .w_ready(w_ready64), .w_data(w_data64),
    .w_idx(w_idx64), .w_last(w_last64), .busy(busy64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference sigma arithmetic on a word of width w, held in 64 bits.
  function automatic logic [63:0] rotr_m(input logic [63:0] x, input int n, input int w);
    logic [63:0] mask;
    logic [63:0] v;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    v = x & mask;
    return ((v >> n) | (v << (w - n))) & mask;
  endfunction

  function automatic logic [63:0] ssig0_m(input logic [63:0] x, input int w);
    if (w == 64) return rotr_m(x, 1, 64) ^ rotr_m(x, 8, 64) ^ (x >> 7);
    return rotr_m(x, 7, 32) ^ rotr_m(x, 18, 32) ^ ((x & 64'hFFFF_FFFF) >> 3);
  endfunction

  function automatic logic [63:0] ssig1_m(input logic [63:0] x, input int w);
    if (w == 64) return rotr_m(x, 19, 64) ^ rotr_m(x, 61, 64) ^ (x >> 6);
    return rotr_m(x, 17, 32) ^ rotr_m(x, 19, 32) ^ ((x & 64'hFFFF_FFFF) >> 10);
  endfunction

  // Queue one block's message words and its full expected schedule.
  task automatic add_block(input bit use64, input logic [63:0] m [16]);
    int          w;
    int          rounds;
    logic [63:0] mask;
    logic [63:0] ws [80];
    exp_t        e;
    w      = use64 ? 64 : 32;
    rounds = use64 ? 80 : 64;
    mask   = use64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    for (int t = 0; t < 16; t++) begin
      ws[t] = m[t] & mask;
      msg_q.push_back(ws[t]);
    end
    for (int t = 16; t < rounds; t++) begin
      ws[t] = (ssig1_m(ws[t-2], w) + ws[t-7] + ssig0_m(ws[t-15], w) + ws[t-16]) & mask;
    end
    for (int t = 0; t < rounds; t++) begin
      e.data = ws[t];
      e.idx  = t;
      e.last = (t == rounds - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic rand_block(output logic [63:0] m [16]);
    for (int i = 0; i < 16; i++) begin
      m[i] = {$urandom, $urandom};
    end
  endtask

  // Feed the queued messages and score every w handshake. With stall_pct > 0,
  // m_valid and w_ready are dropped at random. With gapless set, words must
  // come out on consecutive cycles, starting one cycle after M0 is accepted.
  task automatic run_stream(input bit use64, input int stall_pct, input bit gapless, input string name);
    bit          mv, wr, prev_v, prev_r, seen_w;
    logic        o_mr, o_wv, o_wl, prev_l;
    logic [63:0] md, o_wd, prev_d;
    int          o_wi, prev_i, last_fire, first_m, want_cyc;
    exp_t        e;
    prev_v = 0; prev_r = 1; prev_d = '0; prev_i = 0; prev_l = 0;
    seen_w = 0; last_fire = 0; first_m = -1;
    for (int i = 0; i < 80; i++) got[i] = '0;
    for (int cyc = 0; cyc < 4000 && exp_q.size() > 0; cyc++) begin
      @(negedge clk);
      mv = (msg_q.size() > 0) && ($urandom_range(0, 99) >= stall_pct);
      wr = ($urandom_range(0, 99) >= stall_pct);
      md = mv ? msg_q[0] : {$urandom, $urandom};
      if (use64) begin
        m_valid64 = mv; m_data64 = md; w_ready64 = wr;
      end else begin
        m_valid32 = mv; m_data32 = md[31:0]; w_ready32 = wr;
      end
      #1;
      if (use64) begin
        o_mr = m_ready64; o_wv = w_valid64; o_wd = w_data64; o_wi = int'(w_idx64); o_wl = w_last64;
      end else begin
        o_mr = m_ready32; o_wv = w_valid32; o_wd = {32'h0, w_data32}; o_wi = int'(w_idx32); o_wl = w_last32;
      end
      if (prev_v && !prev_r) begin
        checks++;
        if (o_wv !== 1'b1 || o_wd !== prev_d || o_wi != prev_i || o_wl !== prev_l) begin
          errors++;
          $display("[TB] FAIL %s hold: got v=%b d=%h i=%0d l=%b, required v=1 d=%h i=%0d l=%b",
                   name, o_wv, o_wd, o_wi, o_wl, prev_d, prev_i, prev_l);
        end
      end
      if (o_wv === 1'b1 && !wr) begin
        checks++;
        if (o_mr !== 1'b0) begin
          errors++;
          $display("[TB] FAIL %s backpressure m_ready: got %b, required 0", name, o_mr);
        end
      end
      if (mv && o_mr === 1'b1) begin
        if (first_m < 0) first_m = cyc;
        void'(msg_q.pop_front());
      end
      if (o_wv === 1'b1 && wr) begin
        e = exp_q.pop_front();
        checks++;
        if (o_wd !== e.data || o_wi != e.idx || o_wl !== e.last) begin
          errors++;
          $display("[TB] FAIL %s word: got d=%h i=%0d l=%b, required d=%h i=%0d l=%b",
                   name, o_wd, o_wi, o_wl, e.data, e.idx, e.last);
        end
        if (o_wi >= 0 && o_wi < 80) got[o_wi] = o_wd;
        if (gapless) begin
          want_cyc = seen_w ? last_fire + 1 : first_m + 1;
          checks++;
          if (cyc != want_cyc) begin
            errors++;
            $display("[TB] FAIL %s gap: word %0d at cycle %0d, required cycle %0d", name, o_wi, cyc, want_cyc);
          end
        end
        seen_w = 1; last_fire = cyc;
      end
      prev_v = o_wv; prev_r = wr; prev_d = o_wd; prev_i = o_wi; prev_l = o_wl;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s timeout: %0d words outstanding, required 0", name, exp_q.size());
      exp_q.delete();
      msg_q.delete();
    end
    @(negedge clk);
    m_valid32 = 0; w_ready32 = 1; m_valid64 = 0; w_ready64 = 1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    m_valid32 = 1; w_ready32 = 1;
    #1;
    checks++; if (w_valid32 !== 1'b0) begin errors++; $display("[TB] FAIL reset w_valid: got %b, required 0", w_valid32); end
    checks++; if (w_data32 !== 32'h0) begin errors++; $display("[TB] FAIL reset w_data: got %h, required 0", w_data32); end
    checks++; if (w_idx32 !== 6'd0) begin errors++; $display("[TB] FAIL reset w_idx: got %0d, required 0", w_idx32); end
    checks++; if (w_last32 !== 1'b0) begin errors++; $display("[TB] FAIL reset w_last: got %b, required 0", w_last32); end
    checks++; if (busy32 !== 1'b0) begin errors++; $display("[TB] FAIL reset busy: got %b, required 0", busy32); end
    checks++; if (m_ready32 !== 1'b0) begin errors++; $display("[TB] FAIL reset m_ready: got %b, required 0", m_ready32); end
    checks++; if (w_valid64 !== 1'b0 || busy64 !== 1'b0) begin errors++; $display("[TB] FAIL reset64: got v=%b busy=%b, required 0 0", w_valid64, busy64); end
    @(negedge clk);
    m_valid32 = 0;
    rst = 1'b1;
    #1;
    checks++; if (m_ready32 !== 1'b1) begin errors++; $display("[TB] FAIL idle m_ready: got %b, required 1", m_ready32); end
  endtask

  task automatic test_sha256_abc();
    logic [63:0] m [16];
    for (int i = 0; i < 16; i++) m[i] = '0;
    m[0]  = 64'h6162_6380;
    m[15] = 64'h18;
    add_block(0, m);
    run_stream(0, 0, 1, "abc256");
    checks++; if (got[16] !== 64'h6162_6380) begin errors++; $display("[TB] FAIL abc256 W16: got %h, required 61626380", got[16]); end
    checks++; if (got[17] !== 64'h000F_0000) begin errors++; $display("[TB] FAIL abc256 W17: got %h, required 000f0000", got[17]); end
  endtask

  task automatic test_stalls();
    logic [63:0] m [16];
    for (int b = 0; b < 2; b++) begin
      rand_block(m);
      add_block(0, m);
    end
    run_stream(0, 35, 0, "stall256");
  endtask

  task automatic test_back_to_back();
    logic [63:0] m [16];
    for (int b = 0; b < 3; b++) begin
      rand_block(m);
      add_block(0, m);
    end
    run_stream(0, 0, 1, "b2b256");
  endtask

  task automatic test_abort();
    logic [63:0] m [16];
    int sent;
    bit hit;
    rand_block(m);
    sent = 0; hit = 0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge clk);
      m_valid32 = (sent < 16);
      m_data32  = m[(sent < 16) ? sent : 0][31:0];
      w_ready32 = 1;
      #1;
      if (w_valid32 === 1'b1 && w_idx32 == 6'd30) begin
        hit = 1;
        abort32 = 1;
      end else if (m_valid32 && m_ready32 === 1'b1) begin
        sent++;
      end
    end
    checks++; if (!hit) begin errors++; $display("[TB] FAIL abort reach idx30: got no, required yes"); end
    @(negedge clk);
    abort32 = 0; m_valid32 = 0; w_ready32 = 1;
    #1;
    checks++; if (w_valid32 !== 1'b0) begin errors++; $display("[TB] FAIL abort w_valid: got %b, required 0", w_valid32); end
    checks++; if (busy32 !== 1'b0) begin errors++; $display("[TB] FAIL abort busy: got %b, required 0", busy32); end
    checks++; if (m_ready32 !== 1'b1) begin errors++; $display("[TB] FAIL abort m_ready: got %b, required 1", m_ready32); end
    rand_block(m);
    add_block(0, m);
    run_stream(0, 0, 1, "after_abort");
  endtask

  task automatic test_reset_mid_block();
    logic [63:0] m [16];
    int sent;
    rand_block(m);
    sent = 0;
    for (int c = 0; c < 50 && sent < 7; c++) begin
      @(negedge clk);
      m_valid32 = 1; m_data32 = m[sent][31:0]; w_ready32 = 1;
      #1;
      if (m_ready32 === 1'b1) sent++;
    end
    @(negedge clk);
    m_valid32 = 0;
    #1;
    checks++; if (busy32 !== 1'b1 || w_idx32 !== 6'd6) begin errors++; $display("[TB] FAIL pre-reset: got busy=%b idx=%0d, required 1 6", busy32, w_idx32); end
    rst = 1'b0;
    #1;
    checks++;
    if (w_valid32 !== 1'b0 || w_data32 !== 32'h0 || w_idx32 !== 6'd0 || w_last32 !== 1'b0 ||
        busy32 !== 1'b0 || m_ready32 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset outputs: got v=%b d=%h i=%0d l=%b busy=%b mr=%b, required all 0",
               w_valid32, w_data32, w_idx32, w_last32, busy32, m_ready32);
    end
    @(negedge clk);
    rst = 1'b1;
    rand_block(m);
    add_block(0, m);
    run_stream(0, 0, 1, "after_reset");
  endtask

  task automatic test_sha512_abc();
    logic [63:0] m [16];
    for (int i = 0; i < 16; i++) m[i] = '0;
    m[0]  = 64'h6162_6380_0000_0000;
    m[15] = 64'h18;
    add_block(1, m);
    run_stream(1, 0, 1, "abc512");
    checks++; if (got[16] !== 64'h6162_6380_0000_0000) begin errors++; $display("[TB] FAIL abc512 W16: got %h, required 6162638000000000", got[16]); end
    checks++; if (got[17] !== 64'h0003_0000_0000_00C0) begin errors++; $display("[TB] FAIL abc512 W17: got %h, required 00030000000000c0", got[17]); end
    rand_block(m);
    add_block(1, m);
    rand_block(m);
    add_block(1, m);
    run_stream(1, 25, 0, "stall512");
  endtask

  initial begin
    checks = 0; errors = 0;
    abort32 = 0; m_valid32 = 0; m_data32 = '0; w_ready32 = 1;
    abort64 = 0; m_valid64 = 0; m_data64 = '0; w_ready64 = 1;
    test_reset();
    test_sha256_abc();
    test_stalls();
    test_back_to_back();
    test_abort();
    test_reset_mid_block();
    test_sha512_abc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
